// File: rtl/rgb_palette_lut_pkg.sv
// Shared types and helpers for the writable RGB palette LUT.
// Holds the FSM state type, the default channel width and the default-palette generator.
package rgb_pkg;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    localparam int unsigned CH_W_DEF = 8;
    localparam int unsigned CH_W_MAX = 32;

    // Entry index bits {r,g,b} select all-ones or zero per channel; result is packed {R,G,B} in the low 3*ch_w bits.
    function automatic logic [3*CH_W_MAX-1:0] default_colour(input logic [2:0] idx,
                                                               input int unsigned ch_w);
        logic [3*CH_W_MAX-1:0] w;
        w = '0;
        for (int unsigned j = 0; j < ch_w; j++) begin
            w[2*ch_w + j] = idx[2];
            w[ch_w + j]   = idx[1];
            w[j]          = idx[0];
        end
        return w;
    endfunction

endpackage

// File: rtl/rgb_palette_lut_scale.sv
// One-cycle registered brightness scaler for a single colour channel.
// Output = (ch * (bright+1)) >> 8, updated only when en_i is high.
module rgb_scale #(
    parameter int unsigned CH_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [CH_W-1:0] ch_i,
    input  logic [7:0]      bright_i,
    output logic [CH_W-1:0] ch_o
);

    logic [CH_W+8:0] prod;
    logic [CH_W-1:0] ch_d;
    logic [CH_W-1:0] ch_q;

    always_comb begin
        prod = (CH_W+9)'(ch_i) * ((CH_W+9)'(bright_i) + (CH_W+9)'(1));
        ch_d = CH_W'(prod >> 8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q <= '0;
        end else if (en_i) begin
            ch_q <= ch_d;
        end
    end

    assign ch_o = ch_q;

endmodule

// File: rtl/rgb_palette_lut.sv
// Writable colour palette LUT: self-loads a default palette, then serves pipelined reads.
// Optional brightness scaling stage enabled by defining RGB_BRIGHTNESS_EN.
module rgb_palette_lut
    import rgb_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CH_W   = CH_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   colour,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                init_req,
`ifdef RGB_BRIGHTNESS_EN
    input  logic [7:0]          bright,
`endif
    output logic                busy,
    output logic [3*CH_W-1:0]   rgb,
    output logic                rgb_valid
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned RGB_W = 3 * CH_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("rgb_palette_lut: RD_LAT must be 1 or 2");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == CNT_W'(DEPTH - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (init_req) begin
            state_d = INIT;
            cnt_d   = '0;
        end
    end

    assign busy = (state_q == INIT);

    logic [RGB_W-1:0]   mem [DEPTH];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [RGB_W-1:0]   mem_wdata;
    logic [2:0]         dflt_idx;

    always_comb begin
        dflt_idx = 3'(cnt_q[ADDR_W-1:0]);
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = RGB_W'(default_colour(dflt_idx, CH_W));
        end else begin
            mem_we    = wr_en;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic               rd_en;
    logic [RGB_W-1:0]   rd_data;

    // Write-first bypass: a same-index write in IDLE is returned by the concurrent read.
    always_comb begin
        rd_en   = enable && (state_q == IDLE);
        rd_data = mem[colour];
        if (wr_en && (state_q == IDLE) && (wr_addr == colour)) begin
            rd_data = wr_data;
        end
    end

    logic [RGB_W-1:0]   s1_data_q;
    logic               s1_valid_q;
    logic [RGB_W-1:0]   fin_data;
    logic               fin_valid;
`ifdef RGB_BRIGHTNESS_EN
    logic [7:0]         s1_bright_q;
    logic [7:0]         fin_bright;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
`ifdef RGB_BRIGHTNESS_EN
            s1_bright_q <= '0;
`endif
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q   <= rd_data;
`ifdef RGB_BRIGHTNESS_EN
                s1_bright_q <= bright;
`endif
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [RGB_W-1:0]   s2_data_q;
        logic               s2_valid_q;
`ifdef RGB_BRIGHTNESS_EN
        logic [7:0]         s2_bright_q;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid_q  <= 1'b0;
                s2_data_q   <= '0;
`ifdef RGB_BRIGHTNESS_EN
                s2_bright_q <= '0;
`endif
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q   <= s1_data_q;
`ifdef RGB_BRIGHTNESS_EN
                    s2_bright_q <= s1_bright_q;
`endif
                end
            end
        end

        assign fin_data   = s2_data_q;
        assign fin_valid  = s2_valid_q;
`ifdef RGB_BRIGHTNESS_EN
        assign fin_bright = s2_bright_q;
`endif
    end else begin : g_lat1
        assign fin_data   = s1_data_q;
        assign fin_valid  = s1_valid_q;
`ifdef RGB_BRIGHTNESS_EN
        assign fin_bright = s1_bright_q;
`endif
    end

`ifdef RGB_BRIGHTNESS_EN
    logic [CH_W-1:0]    r_s, g_s, b_s;
    logic               out_valid_q;

    rgb_scale #(.CH_W(CH_W)) u_scale_r (
        .clk      (clk),
        .rst      (rst),
        .en_i     (fin_valid),
        .ch_i     (fin_data[3*CH_W-1:2*CH_W]),
        .bright_i (fin_bright),
        .ch_o     (r_s)
    );

    rgb_scale #(.CH_W(CH_W)) u_scale_g (
        .clk      (clk),
        .rst      (rst),
        .en_i     (fin_valid),
        .ch_i     (fin_data[2*CH_W-1:CH_W]),
        .bright_i (fin_bright),
        .ch_o     (g_s)
    );

    rgb_scale #(.CH_W(CH_W)) u_scale_b (
        .clk      (clk),
        .rst      (rst),
        .en_i     (fin_valid),
        .ch_i     (fin_data[CH_W-1:0]),
        .bright_i (fin_bright),
        .ch_o     (b_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= fin_valid;
        end
    end

    assign rgb       = {r_s, g_s, b_s};
    assign rgb_valid = out_valid_q;
`else
    assign rgb       = fin_data;
    assign rgb_valid = fin_valid;
`endif

endmodule
